mp_add_seq: RTL and testbench
=============================

Name: mp_add_seq

Overview:
- Byte-serial multi-precision adder sequencer; sits directly upstream of, and drives, the team's 8-bit ripple-carry adder RCA.
- Accepts two NBYTES-wide operands through a valid/ready handshake.
- Feeds one byte pair per cycle into a single RCA instance and registers the carry between cycles.
- Assembles the full-width sum and presents it on a valid/ready output.

Parameters:
- NBYTES, 4, operand width in bytes (legal range 2..16); data width W = 8*NBYTES.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  initial carry-in.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  result, a+b+cin mod 2^W.
- cout  output  1  carry out of byte NBYTES-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: rst_n low at a rising edge.
  - State goes to IDLE; byte counter, operand, result and carry registers are cleared.
  - Outputs after reset: in_ready=1, out_valid=0, sum=0, cout=0, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, capture a, b, cin; set cnt=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, RCA adds byte a_reg[7:0] + b_reg[7:0] + carry_reg.
  - At the edge:
    - a_reg and b_reg shift right by 8.
    - The RCA 8-bit sum shifts into the top of the result register; the result register shifts right by 8.
    - carry_reg takes the RCA carry out.
    - cnt increments.
  - When cnt==NBYTES-1 at the edge, go to DONE and latch cout from the RCA carry out.
- DONE:
  - out_valid=1.
  - sum and cout stay stable until the handshake.
  - On out_valid && out_ready, go to IDLE; the next operands can be accepted on the following cycle.
- Latency: out_valid rises exactly NBYTES rising edges after the accepting edge.
- Throughput: at most one operation per NBYTES+2 cycles when out_ready is held high.
- Inputs a, b, cin are don't-care outside the accept cycle; changes during RUN have no effect.
- in_valid while busy is ignored and not queued; the upstream holds it until in_ready.
- sum/cout retain the last result after the handshake until the next DONE; only out_valid qualifies them.
- rst_n low in any state, including mid-RUN, aborts the operation. The next cycle shows the reset values; no partial result is ever flagged valid.
- Wrap-around: sum is modulo 2^W; the overflow bit appears only on cout.

Optional Feature:
- Macro MP_ADD_SEQ_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - When sub=1, every B byte is inverted before the RCA and the initial carry is forced to 1 (cin ignored), so the result is a-b mod 2^W.
  - cout=1 means no borrow; cout=0 means a borrow occurred.
  - sub=0 behaves exactly as the base block.
- Undefined: no sub port; addition only.

Test Plan:
- NBYTES=4, a=0x000000FF, b=0x00000001, cin=0 -> out_valid exactly 4 edges after accept; sum=0x00000100, cout=0.
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1; the carry ripples across all 4 bytes.
- Hold out_ready=0 for 3 cycles in DONE with a=0x12345678, b=0x11111111 -> sum=0x23456789 held stable, in_ready=0, busy=1 throughout; IDLE one edge after out_ready=1.
- Drive rst_n=0 one cycle after 2 RUN edges -> next cycle out_valid=0, in_ready=1, sum=0, cout=0; a new operation a=1, b=2 then yields sum=3.
- Two back-to-back ops with out_ready=1: op1 a=0x80000000, b=0x80000000 (sum=0, cout=1); op2 a=7, b=8 (sum=0x0F, cout=0) -> op2 accepted 1 cycle after op1 handshake.
- With MP_ADD_SEQ_SUB_EN: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0; a=7, b=5, sub=1 -> sum=0x00000002, cout=1.

Source files
------------

// File: rtl/mp_add_seq.sv
// Byte-serial multi-precision adder: streams operand bytes through one 8-bit ripple-carry adder.
// Define MP_ADD_SEQ_SUB_EN to add the `sub` port (a-b via inverted B and forced carry-in).

module mp_add_seq_rca8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);

    logic [8:0] c_s;

    // Bit-level ripple carry chain
    always_comb begin
        c_s    = 9'd0;
        s      = 8'd0;
        c_s[0] = ci;
        for (int i = 0; i < 8; i++) begin
            s[i]     = x[i] ^ y[i] ^ c_s[i];
            c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
        end
        co = c_s[8];
    end

endmodule

module mp_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
`ifdef MP_ADD_SEQ_SUB_EN
    input  logic                  sub,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  busy
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES);
    localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic [1:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-9:0]  res_r;
    logic          carry_r;
    logic [W-1:0]  sum_r;
    logic          cout_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic          busy_r;
`ifdef MP_ADD_SEQ_SUB_EN
    logic          sub_r;
`endif

    logic [7:0]    b_byte_s;
    logic          init_carry_s;
    logic [7:0]    rca_sum_s;
    logic          rca_co_s;
    logic [W-1:0]  res_next_s;

    // B-byte conditioning and initial carry selection
    always_comb begin
        b_byte_s     = b_r[7:0];
        init_carry_s = cin;
`ifdef MP_ADD_SEQ_SUB_EN
        if (sub_r) begin
            b_byte_s = ~b_r[7:0];
        end else begin
            b_byte_s = b_r[7:0];
        end
        if (sub) begin
            init_carry_s = 1'b1;
        end else begin
            init_carry_s = cin;
        end
`endif
    end

    mp_add_seq_rca8 u_rca (
        .x  (a_r[7:0]),
        .y  (b_byte_s),
        .ci (carry_r),
        .s  (rca_sum_s),
        .co (rca_co_s)
    );

    // Newest byte enters at the top; after the final byte this is the full sum
    assign res_next_s = {rca_sum_s, res_r};

    // State machine, operand/result shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            res_r       <= {(W-8){1'b0}};
            carry_r     <= 1'b0;
            sum_r       <= {W{1'b0}};
            cout_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef MP_ADD_SEQ_SUB_EN
            sub_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r        <= a;
                        b_r        <= b;
                        carry_r    <= init_carry_s;
                        cnt_r      <= '0;
                        state_r    <= ST_RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
`ifdef MP_ADD_SEQ_SUB_EN
                        sub_r      <= sub;
`endif
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_r     <= {8'h00, a_r[W-1:8]};
                    b_r     <= {8'h00, b_r[W-1:8]};
                    res_r   <= res_next_s[W-1:8];
                    carry_r <= rca_co_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_r     <= ST_DONE;
                        sum_r       <= res_next_s;
                        cout_r      <= rca_co_s;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq: driver pushes expected results, a negedge monitor pops at each output handshake.
module tb_mp_add_seq;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef MP_ADD_SEQ_SUB_EN
    logic         sub;
`endif

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    mp_add_seq #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef MP_ADD_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; hold>0 keeps out_ready low for that many DONE cycles
    task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_cin,
                         input logic [W-1:0] exp_s, input logic exp_c, input int hold);
        int lat;
        chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        a         = op_a;
        b         = op_b;
        cin       = op_cin;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        exp_q.push_back('{s: exp_s, c: exp_c});
        tick;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        cin      = 1'($urandom_range(0, 1));
        chk("in_ready_in_run", {63'd0, in_ready}, 64'd0);
        chk("busy_in_run", {63'd0, busy}, 64'd1);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 4 * NBYTES) begin
            tick;
            lat++;
        end
        chk("latency_edges", 64'(lat), 64'(NBYTES));
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                chk("hold_sum", {32'd0, sum}, {32'd0, exp_s});
                chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
                chk("hold_busy", {63'd0, busy}, 64'd1);
                tick;
            end
            out_ready = 1'b1;
        end
        tick;
        chk("out_valid_after_hs", {63'd0, out_valid}, 64'd0);
        chk("in_ready_after_hs", {63'd0, in_ready}, 64'd1);
        chk("busy_after_hs", {63'd0, busy}, 64'd0);
        chk("sum_retained", {32'd0, sum}, {32'd0, exp_s});
        chk("cout_retained", {63'd0, cout}, {63'd0, exp_c});
    endtask

    // Monitor: compare against the scoreboard whenever a result is handed over
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got sum 0x%0h cout %0d, expected no result", sum, cout);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sum", {32'd0, sum}, {32'd0, mon_e.s});
                chk("cout", {63'd0, cout}, {63'd0, mon_e.c});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 32'hA5A5A5A5;
        b         = 32'h5A5A5A5A;
        cin       = 1'b1;
`ifdef MP_ADD_SEQ_SUB_EN
        sub       = 1'b0;
`endif
        tick;
        tick;
        rst_n = 1'b1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {32'd0, sum}, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        tick;

        do_op(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 0);
        do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 0);
        do_op(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 3);
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 0);

        // Abort mid-RUN: no result must ever be flagged for this operation
        a        = 32'h00000011;
        b        = 32'h00000022;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        chk("abort_sum", {32'd0, sum}, 64'd0);
        chk("abort_cout", {63'd0, cout}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("abort_no_valid", {63'd0, out_valid}, 64'd0);
        end
        do_op(32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 0);

        // Back-to-back: second op accepted on the edge after the first handshake
        do_op(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 0);
        do_op(32'h00000007, 32'h00000008, 1'b0, 32'h0000000F, 1'b0, 0);

`ifdef MP_ADD_SEQ_SUB_EN
        sub = 1'b1;
        do_op(32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 0);
        do_op(32'h00000007, 32'h00000005, 1'b0, 32'h00000002, 1'b1, 0);
        sub = 1'b0;
        do_op(32'h00000007, 32'h00000005, 1'b0, 32'h0000000C, 1'b0, 0);
`endif

        tick;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
